// File: rtl/inst_sram_axi_bridge_pkg.sv
// Shared AXI encodings and sizing for the instruction SRAM-to-AXI read bridge.
package inst_sram_axi_bridge_pkg;

    // Width of the outstanding-request counter (supports up to 7 in flight).
    localparam int CNT_W = 3;

    // AXI read-channel encodings used by the bridge.
    localparam logic [7:0] AXI_LEN_1BEAT  = 8'd0;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // True when a consumed R beat is malformed: error response or a missing RLAST
    // on what must always be a single-beat burst.
    function automatic logic beat_is_bad(input logic [1:0] resp, input logic last);
        return (resp != AXI_RESP_OKAY) || !last;
    endfunction

endpackage

// File: rtl/inst_sram_axi_bridge.sv
// Instruction fetch bridge: SRAM-like request/response bus from IF to single-beat
// AXI4 reads. One AR slot, in-order responses (single ARID), up to MAX_OUTST
// accepted-but-unanswered fetches so IF can keep its request stage pipelined.
module inst_sram_axi_bridge
    import inst_sram_axi_bridge_pkg::*;
#(
    parameter int         MAX_OUTST = 2,
    parameter logic [3:0] AXI_ID    = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,

    // SRAM-like instruction bus (IF side)
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    // AXI4 read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    // AXI4 read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    // Sticky protocol/slave error flag
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    logic             r_arvalid;
    logic [31:0]      r_araddr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;

    logic             w_ar_free;
    logic             w_addr_ok;
    logic             w_rready;
    logic             w_data_ok;
    logic             w_err_evt;
    logic             w_unused_rid;

    // All reads share one ID, so RID carries no information for us.
    assign w_unused_rid = ^rid;

    // The AR slot can take a new address when empty or when it drains this cycle.
    assign w_ar_free = !r_arvalid || arready;
    // Acceptance uses the registered count, so a full bridge resumes the cycle
    // after a response rather than in the same cycle.
    assign w_addr_ok = inst_req && w_ar_free && (r_cnt < MAX_CNT);
    // Only accept R beats we are actually waiting for; IF always sinks data.
    assign w_rready  = (r_cnt != '0);
    assign w_data_ok = rvalid && w_rready;
    // Unexpected beat, or a consumed beat that is malformed.
    assign w_err_evt = (rvalid && !w_rready) || (w_data_ok && beat_is_bad(rresp, rlast));

    // AR slot: load on acceptance (also covers back-to-back handshake), clear on
    // handshake, otherwise hold address/valid stable under backpressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
        end else if (w_addr_ok) begin
            r_arvalid <= 1'b1;
            r_araddr  <= inst_addr;
        end else if (r_arvalid && arready) begin
            r_arvalid <= 1'b0;
        end
    end

    // Outstanding count: accepted requests minus returned responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else begin
            case ({w_addr_ok, w_data_ok})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bus_err <= 1'b0;
        end else if (w_err_evt) begin
            r_bus_err <= 1'b1;
        end
    end

    assign inst_addr_ok = w_addr_ok;
    assign inst_data_ok = w_data_ok;
    assign inst_rdata   = rdata;

    assign arid    = AXI_ID;
    assign araddr  = r_araddr;
    assign arlen   = AXI_LEN_1BEAT;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign arvalid = r_arvalid;

    assign rready  = w_rready;
    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Directed bench for inst_sram_axi_bridge (MAX_OUTST=2): a cycle-by-cycle vector
// table for single and pipelined fetches, plus hand sequences for AR backpressure,
// error handling and asynchronous reset.
module tb_inst_sram_axi_bridge;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        bus_err;

    int tests_run;
    int tests_failed;

    inst_sram_axi_bridge #(.MAX_OUTST(2), .AXI_ID(4'd0)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .arid         (arid),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready)
        ,.bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        e_addr_ok;
        logic        e_data_ok;
        logic        e_arvalid;
        logic [31:0] e_araddr;
        logic        e_rready;
        logic        e_err;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic req, logic [31:0] addr, logic ar_rdy, logic rv,
                                logic [31:0] rd, logic [1:0] rs, logic e_aok,
                                logic e_dok, logic e_arv, logic [31:0] e_ara,
                                logic e_rrdy, logic e_err);
        vec_t v;
        v.req = req; v.addr = addr; v.arready = ar_rdy; v.rvalid = rv;
        v.rdata = rd; v.rresp = rs; v.e_addr_ok = e_aok; v.e_data_ok = e_dok;
        v.e_arvalid = e_arv; v.e_araddr = e_ara; v.e_rready = e_rrdy; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic ar_rdy,
                         input logic rv, input logic [31:0] rd, input logic [1:0] rs,
                         input logic rl);
        inst_req = req; inst_addr = addr; arready = ar_rdy;
        rvalid = rv; rdata = rd; rresp = rs; rlast = rl;
    endtask

    task automatic check_all(input string tag, input logic aok, input logic dok,
                             input logic arv, input logic [31:0] ara,
                             input logic rrdy, input logic err);
        chk({tag, ".addr_ok"}, 32'(inst_addr_ok), 32'(aok));
        chk({tag, ".data_ok"}, 32'(inst_data_ok), 32'(dok));
        chk({tag, ".arvalid"}, 32'(arvalid), 32'(arv));
        chk({tag, ".araddr"},  araddr, ara);
        chk({tag, ".rready"},  32'(rready), 32'(rrdy));
        chk({tag, ".bus_err"}, 32'(bus_err), 32'(err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 1'b0;
        rid          = 4'd0;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);

        // req  addr         ardy rv rdata        rresp aok dok arv araddr       rrdy err
        vecs[0]  = mk(1, 32'h1FC00000, 1, 0, 32'h0,        2'b00, 1, 0, 0, 32'h0,        0, 0);
        vecs[1]  = mk(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 1, 32'h1FC00000, 1, 0);
        vecs[2]  = mk(0, 32'h0,        1, 1, 32'h3C1D0000, 2'b00, 0, 1, 0, 32'h1FC00000, 1, 0);
        vecs[3]  = mk(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h1FC00000, 0, 0);
        vecs[4]  = mk(1, 32'h100,      1, 0, 32'h0,        2'b00, 1, 0, 0, 32'h1FC00000, 0, 0);
        vecs[5]  = mk(1, 32'h104,      1, 0, 32'h0,        2'b00, 1, 0, 1, 32'h100,      1, 0);
        vecs[6]  = mk(1, 32'h108,      1, 0, 32'h0,        2'b00, 0, 0, 1, 32'h104,      1, 0);
        vecs[7]  = mk(1, 32'h108,      1, 1, 32'hD0000100, 2'b00, 0, 1, 0, 32'h104,      1, 0);
        vecs[8]  = mk(1, 32'h108,      1, 1, 32'hD0000104, 2'b00, 1, 1, 0, 32'h104,      1, 0);
        vecs[9]  = mk(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 1, 32'h108,      1, 0);
        vecs[10] = mk(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h108,      1, 0);
        vecs[11] = mk(0, 32'h0,        1, 1, 32'hD0000108, 2'b00, 0, 1, 0, 32'h108,      1, 0);
        vecs[12] = mk(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h108,      0, 0);

        // Reset state while held in reset
        @(negedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("arid",    32'(arid),    32'h0);
        chk("arlen",   32'(arlen),   32'h0);
        chk("arsize",  32'(arsize),  32'h2);
        chk("arburst", 32'(arburst), 32'h1);
        @(negedge clk);
        resetn = 1'b1;

        // Table: single fetch then pipelined fetches with R lag 3
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].addr, vecs[i].arready, vecs[i].rvalid,
                  vecs[i].rdata, vecs[i].rresp, 1'b1);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_addr_ok, vecs[i].e_data_ok,
                      vecs[i].e_arvalid, vecs[i].e_araddr, vecs[i].e_rready, vecs[i].e_err);
            if (vecs[i].e_data_ok)
                chk($sformatf("vec%0d.rdata", i), inst_rdata, vecs[i].rdata);
            $display("[TB] vec %0d req=%0b addr=0x%08h aok=%0b dok=%0b rdata=0x%08h",
                     i, inst_req, inst_addr, inst_addr_ok, inst_data_ok, inst_rdata);
        end

        // AR backpressure: first request accepted, AR stalls 5 cycles
        @(negedge clk);
        drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
        #1;
        check_all("bp.accept", 1'b1, 1'b0, 1'b0, 32'h108, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h204, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
            #1;
            check_all($sformatf("bp.stall%0d", k), 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
            $display("[TB] bp stall %0d arvalid=%0b araddr=0x%08h aok=%0b",
                     k, arvalid, araddr, inst_addr_ok);
        end
        // Handshake and new acceptance in the same cycle
        @(negedge clk);
        drive(1'b1, 32'h204, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
        #1;
        check_all("bp.b2b", 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hA0000200, 2'b00, 1'b1);
        #1;
        check_all("bp.r0", 1'b0, 1'b1, 1'b1, 32'h204, 1'b1, 1'b0);
        chk("bp.r0.rdata", inst_rdata, 32'hA0000200);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hA0000204, 2'b00, 1'b1);
        #1;
        check_all("bp.r1", 1'b0, 1'b1, 1'b0, 32'h204, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
        #1;
        check_all("bp.idle", 1'b0, 1'b0, 1'b0, 32'h204, 1'b0, 1'b0);
        $display("[TB] backpressure sequence done");

        // SLVERR beat: data still returned, bus_err sticky afterwards
        @(negedge clk);
        drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
        #1;
        check_all("err.req", 1'b1, 1'b0, 1'b0, 32'h204, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hBAD00300, 2'b10, 1'b1);
        #1;
        check_all("err.beat", 1'b0, 1'b1, 1'b0, 32'h300, 1'b1, 1'b0);
        chk("err.beat.rdata", inst_rdata, 32'hBAD00300);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
            #1;
            check_all($sformatf("err.sticky%0d", k), 1'b0, 1'b0, 1'b0, 32'h300, 1'b0, 1'b1);
        end
        $display("[TB] slverr sequence bus_err=%0b", bus_err);

        // Missing RLAST on a consumed beat also flags an error
        do_reset();
        @(negedge clk);
        drive(1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h11110400, 2'b00, 1'b0);
        #1;
        check_all("nolast.beat", 1'b0, 1'b1, 1'b0, 32'h400, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
        #1;
        chk("nolast.err", 32'(bus_err), 32'h1);
        $display("[TB] missing-rlast sequence bus_err=%0b", bus_err);

        // Stray R beat with nothing outstanding: not consumed, error flagged
        do_reset();
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h55555555, 2'b00, 1'b1);
        #1;
        check_all("stray.beat", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
        #1;
        chk("stray.err", 32'(bus_err), 32'h1);
        $display("[TB] stray-beat sequence bus_err=%0b", bus_err);

        // Async reset with two requests outstanding (and bus_err set)
        @(negedge clk);
        drive(1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'h504, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
        #1;
        check_all("ar.pre", 1'b0, 1'b0, 1'b1, 32'h504, 1'b1, 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        check_all("ar.async", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b1, 32'h600, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
        #1;
        check_all("ar.after", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        $display("[TB] async reset sequence arvalid=%0b rready=%0b bus_err=%0b",
                 arvalid, rready, bus_err);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
